// File: rtl/sram_axi_bridge_if.sv
// AXI4-Lite channel bundle between the SRAM bridge (master) and the memory system (slave).
interface sram_axi_bridge_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/sram_axi_bridge.sv
// Single-outstanding SRAM-port to AXI4-Lite bridge; stalls the core until each bus transaction completes.
//
// state   | meaning
// IDLE    | waiting for req_en, captures request
// RD_ADDR | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for rvalid
// WR_REQ  | awvalid/wvalid high until each handshakes
// WR_RESP | bready high, waiting for bvalid
// DONE    | stall released for one cycle, core advances
module sram_axi_bridge #(
   parameter bit ALIGN = 1'b1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                req_en,
   input  logic [3:0]          req_wen,
   input  logic [31:0]         req_addr,
   input  logic [31:0]         req_wdata,
   output logic [31:0]         req_rdata,
   output logic                stall,
   output logic                bus_err,
   sram_axi_bridge_if.master   axi
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_ADDR = 3'd1;
   localparam logic [2:0] RD_DATA = 3'd2;
   localparam logic [2:0] WR_REQ  = 3'd3;
   localparam logic [2:0] WR_RESP = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   logic [2:0]  state_q,   state_d;
   logic [31:0] addr_q,    addr_d;
   logic [3:0]  wen_q,     wen_d;
   logic [31:0] wdata_q,   wdata_d;
   logic [31:0] rdata_q,   rdata_d;
   logic        bus_err_q, bus_err_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q,  w_done_d;
   logic [31:0] bus_addr;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wen_d     = wen_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      bus_err_d = bus_err_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: begin
            if (req_en) begin
               addr_d    = req_addr;
               wen_d     = req_wen;
               wdata_d   = req_wdata;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = (req_wen != 4'b0000) ? WR_REQ : RD_ADDR;
            end
         end
         RD_ADDR: begin
            if (axi.arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (axi.rvalid) begin
               rdata_d = axi.rdata;
               if (axi.rresp != 2'b00) bus_err_d = 1'b1;
               state_d = DONE;
            end
         end
         WR_REQ: begin
            // Each channel finishes independently; leave as soon as both are done.
            aw_done_d = aw_done_q | axi.awready;
            w_done_d  = w_done_q  | axi.wready;
            if (aw_done_d && w_done_d) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (axi.bvalid) begin
               if (axi.bresp != 2'b00) bus_err_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wen_q     <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wen_q     <= wen_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         bus_err_q <= bus_err_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign bus_addr    = ALIGN ? {addr_q[31:2], 2'b00} : addr_q;

   assign axi.araddr  = bus_addr;
   assign axi.awaddr  = bus_addr;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wen_q;
   assign axi.arvalid = (state_q == RD_ADDR);
   assign axi.rready  = (state_q == RD_DATA);
   assign axi.awvalid = (state_q == WR_REQ) && !aw_done_q;
   assign axi.wvalid  = (state_q == WR_REQ) && !w_done_q;
   assign axi.bready  = (state_q == WR_RESP);

   assign req_rdata = rdata_q;
   assign bus_err   = bus_err_q;
   assign stall     = ((state_q == IDLE) && req_en) ||
                      ((state_q != IDLE) && (state_q != DONE));

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: cycle-exact read/write sequences against a hand-driven AXI slave.
module tb_sram_axi_bridge;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_en = 1'b0;
   logic [3:0]  req_wen = 4'h0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [31:0] req_rdata;
   logic        stall;
   logic        bus_err;

   int n_cmp = 0;
   int n_err = 0;

   sram_axi_bridge_if axi ();

   sram_axi_bridge #(.ALIGN(1'b1)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_en    (req_en),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_rdata (req_rdata),
      .stall     (stall),
      .bus_err   (bus_err),
      .axi       (axi.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic slave_idle();
      axi.arready = 1'b0;
      axi.rdata   = 32'h0;
      axi.rresp   = 2'b00;
      axi.rvalid  = 1'b0;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bresp   = 2'b00;
      axi.bvalid  = 1'b0;
   endtask

   task automatic request(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data);
      req_en    = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = data;
   endtask

   initial begin
      slave_idle();
      // ---------------- reset state ----------------
      tick(); tick();
      chk("rst_stall",   {31'h0, stall},       32'h0);
      chk("rst_valids",  {27'h0, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 32'h0);
      chk("rst_rdata",   req_rdata,            32'h0);
      chk("rst_buserr",  {31'h0, bus_err},     32'h0);
      resetn = 1'b1;
      tick();

      // ---------------- zero-wait read ----------------
      request(4'h0, 32'h1FC0_0004, 32'h0); #1;                       // cycle 0
      chk("rd_c0_stall",   {31'h0, stall},       32'h1);
      chk("rd_c0_arvalid", {31'h0, axi.arvalid}, 32'h0);
      tick(); axi.arready = 1'b1; #1;                                 // cycle 1
      chk("rd_c1_arvalid", {31'h0, axi.arvalid}, 32'h1);
      chk("rd_c1_araddr",  axi.araddr,           32'h1FC0_0004);
      chk("rd_c1_stall",   {31'h0, stall},       32'h1);
      tick(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'h2410_0001; #1; // cycle 2
      chk("rd_c2_rready",  {31'h0, axi.rready},  32'h1);
      chk("rd_c2_arvalid", {31'h0, axi.arvalid}, 32'h0);
      chk("rd_c2_stall",   {31'h0, stall},       32'h1);
      tick(); slave_idle(); #1;                                       // cycle 3 (DONE, req_en still old)
      chk("rd_c3_stall",   {31'h0, stall},       32'h0);
      chk("rd_c3_rdata",   req_rdata,            32'h2410_0001);
      chk("rd_c3_rready",  {31'h0, axi.rready},  32'h0);
      req_en = 1'b0;
      tick();                                                         // cycle 4
      chk("rd_c4_stall",   {31'h0, stall},       32'h0);
      chk("rd_c4_arvalid", {31'h0, axi.arvalid}, 32'h0);

      // ---------------- zero-wait aligned write ----------------
      request(4'b0011, 32'h8000_0102, 32'hDEAD_BEEF); #1;
      chk("wr_c0_stall",   {31'h0, stall}, 32'h1);
      tick(); axi.awready = 1'b1; axi.wready = 1'b1; #1;
      chk("wr_c1_valids",  {30'h0, axi.awvalid, axi.wvalid}, 32'h3);
      chk("wr_c1_awaddr",  axi.awaddr,            32'h8000_0100);
      chk("wr_c1_wstrb",   {28'h0, axi.wstrb},    32'h3);
      chk("wr_c1_wdata",   axi.wdata,             32'hDEAD_BEEF);
      tick(); axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; #1;
      chk("wr_c2_bready",  {31'h0, axi.bready},   32'h1);
      chk("wr_c2_valids",  {30'h0, axi.awvalid, axi.wvalid}, 32'h0);
      tick(); slave_idle(); #1;
      chk("wr_c3_stall",   {31'h0, stall},        32'h0);
      chk("wr_c3_rdata",   req_rdata,             32'h2410_0001);
      chk("wr_c3_buserr",  {31'h0, bus_err},      32'h0);
      req_en = 1'b0;
      tick();

      // ---------------- write with awready delayed 3 cycles ----------------
      request(4'hF, 32'h0000_0010, 32'h1234_5678); #1;                // cycle 0
      tick(); axi.wready = 1'b1; #1;                                  // cycle 1
      chk("aw_c1_valids",  {30'h0, axi.awvalid, axi.wvalid}, 32'h3);
      tick(); axi.wready = 1'b0; #1;                                  // cycle 2
      chk("aw_c2_valids",  {30'h0, axi.awvalid, axi.wvalid}, 32'h2);
      chk("aw_c2_stall",   {31'h0, stall},        32'h1);
      tick(); #1;                                                     // cycle 3
      chk("aw_c3_valids",  {30'h0, axi.awvalid, axi.wvalid}, 32'h2);
      tick(); axi.awready = 1'b1; #1;                                 // cycle 4
      chk("aw_c4_awvalid", {31'h0, axi.awvalid},  32'h1);
      chk("aw_c4_bready",  {31'h0, axi.bready},   32'h0);
      tick(); axi.awready = 1'b0; axi.bvalid = 1'b1; #1;              // cycle 5
      chk("aw_c5_bready",  {31'h0, axi.bready},   32'h1);
      chk("aw_c5_awvalid", {31'h0, axi.awvalid},  32'h0);
      chk("aw_c5_stall",   {31'h0, stall},        32'h1);
      tick(); slave_idle(); #1;                                       // cycle 6
      chk("aw_c6_stall",   {31'h0, stall},        32'h0);
      req_en = 1'b0;
      tick();

      // ---------------- back-to-back reads 0x0 then 0x4 ----------------
      request(4'h0, 32'h0, 32'h0);
      axi.arready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         axi.rvalid = (c == 2) || (c == 6);
         axi.rdata  = (c == 2) ? 32'hA0 : 32'hA4;
         if (c == 3) req_addr = 32'h4;
         if (c == 7) req_en = 1'b0;
         #1;
         chk($sformatf("b2b_c%0d_arvalid", c), {31'h0, axi.arvalid},
             ((c == 1) || (c == 5)) ? 32'h1 : 32'h0);
         if (c == 1) chk("b2b_araddr0", axi.araddr, 32'h0);
         if (c == 5) chk("b2b_araddr1", axi.araddr, 32'h4);
         if (c == 3) chk("b2b_rdata0",  req_rdata,  32'hA0);
         if (c == 7) chk("b2b_rdata1",  req_rdata,  32'hA4);
         if (c == 8) chk("b2b_c8_stall", {31'h0, stall}, 32'h0);
         tick();
      end
      slave_idle();

      // ---------------- SLVERR read sets sticky bus_err ----------------
      request(4'h0, 32'h20, 32'h0);
      tick(); axi.arready = 1'b1; #1;
      tick(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rresp = 2'b10; axi.rdata = 32'h55; #1;
      chk("err_c2_buserr", {31'h0, bus_err}, 32'h0);
      tick(); slave_idle(); #1;
      chk("err_c3_buserr", {31'h0, bus_err}, 32'h1);
      chk("err_c3_stall",  {31'h0, stall},   32'h0);
      chk("err_c3_rdata",  req_rdata,        32'h55);
      req_en = 1'b0;
      tick();
      request(4'h1, 32'h30, 32'h0000_00AA);
      tick(); axi.awready = 1'b1; axi.wready = 1'b1; #1;
      tick(); axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; #1;
      tick(); slave_idle(); req_en = 1'b0; #1;
      chk("err_after_ok_wr", {31'h0, bus_err}, 32'h1);
      tick();

      // ---------------- reset in RD_DATA ----------------
      request(4'h0, 32'h40, 32'h0);
      tick(); axi.arready = 1'b1; #1;
      tick(); axi.arready = 1'b0; #1;
      chk("rst_mid_rready_pre", {31'h0, axi.rready}, 32'h1);
      req_en = 1'b0;
      resetn = 1'b0;
      #1;
      chk("rst_mid_rready", {31'h0, axi.rready}, 32'h0);
      chk("rst_mid_stall",  {31'h0, stall},      32'h0);
      chk("rst_mid_rdata",  req_rdata,           32'h0);
      chk("rst_mid_buserr", {31'h0, bus_err},    32'h0);
      tick();
      resetn = 1'b1;
      tick();
      chk("rst_rel_stall",  {31'h0, stall},      32'h0);
      request(4'h0, 32'h44, 32'h0);
      tick(); #1;
      chk("rst_rel_arvalid", {31'h0, axi.arvalid}, 32'h1);
      chk("rst_rel_araddr",  axi.araddr,           32'h44);
      resetn = 1'b0;
      req_en = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
